mio_bus_ctrl: RTL and testbench
===============================

// Module: mio_bus_ctrl
// PURPOSE
//  Memory/IO bus controller downstream of the pipeline CPU's MEM stage.
//  - Consumes the CPU's data-side request: address, write data, write enable and MIO strobe.
//  - Decodes each access to the data RAM or to the peripheral bus.
//  - Runs the access: fixed latency for RAM, req/ack handshake with timeout for peripherals.
//  - Returns read data and a one-cycle mio_ready completion pulse to the CPU.
// PARAMETERS
//  RAM_AW      10     RAM word-address width (RAM holds 2^RAM_AW words)
//  PER_HI      4'hE   addr[31:28] >= PER_HI selects the peripheral bus; lower values select RAM
//  TIMEOUT     16     maximum cycles per_req may wait for per_ack (must be >= 2)
//  ERR_DATA    32'hDEAD_BEEF  read data returned on a peripheral timeout
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  cpu_en     in   1      1 = new requests may be accepted
//  cpu_mio    in   1      CPU access request, level-held until mio_ready is seen
//  cpu_we     in   1      1 = write, 0 = read
//  cpu_addr   in   32     byte address; bits [1:0] are ignored
//  cpu_wdata  in   32     store data
//  cpu_rdata  out  32     load data, valid while mio_ready=1
//  mio_ready  out  1      one-cycle pulse: access complete
//  ram_en     out  1      RAM enable
//  ram_we     out  1      RAM write enable
//  ram_addr   out  RAM_AW RAM word address = cpu_addr[RAM_AW+1:2]
//  ram_wdata  out  32     RAM write data
//  ram_rdata  in   32     RAM read data, synchronous with 1-cycle latency
//  per_req    out  1      peripheral request, held until ack or timeout
//  per_we     out  1      peripheral write
//  per_addr   out  32     peripheral address, latched
//  per_wdata  out  32     peripheral write data, latched
//  per_rdata  in   32     peripheral read data, valid with per_ack
//  per_ack    in   1      peripheral acknowledge, sampled only while per_req=1
//  bus_err    out  1      sticky flag: set by a peripheral timeout
//  err_clr    in   1      synchronous clear of bus_err
// BEHAVIOUR
//  - Reset (rst=0, asynchronous):
//    - state=IDLE.
//    - All outputs 0: mio_ready, cpu_rdata, ram_*, per_*, bus_err.
//  - Reset mid-access: per_req and ram_en drop immediately; the in-flight access is abandoned, no mio_ready.
//  - FSM states: IDLE, RAM_ACC, RAM_WAIT, PER_ACC, DONE.
//  - IDLE:
//    - Request accepted at a posedge with cpu_mio=1 and cpu_en=1.
//    - Accept latches addr, wdata and we.
//    - Next state is RAM_ACC or PER_ACC according to the PER_HI decode.
//  - RAM_ACC (1 cycle):
//    - ram_en=1; ram_we=latched we.
//    - Write -> DONE.
//    - Read -> RAM_WAIT.
//  - RAM_WAIT (1 cycle): capture ram_rdata into cpu_rdata -> DONE.
//  - RAM latency, accept edge to mio_ready: write 2 cycles, read 3 cycles.
//  - PER_ACC:
//    - per_req=1 with per_we, per_addr and per_wdata stable.
//    - Timeout counter starts at 0, increments each cycle.
//    - per_ack=1: capture per_rdata (reads) -> DONE.
//    - Counter reaches TIMEOUT-1 with no ack: cpu_rdata=ERR_DATA, bus_err<=1 -> DONE.
//    - per_ack arriving in the same cycle as the timeout: ack wins, no error.
//  - DONE (1 cycle):
//    - mio_ready=1, per_req=0 -> IDLE.
//    - The CPU drops cpu_mio in the cycle after it sees mio_ready.
//    - cpu_mio still high in IDLE is a new request.
//  - cpu_rdata holds its last value until the next completion; writes leave it unchanged.
//  - cpu_en=0 blocks only acceptance in IDLE; an in-flight access always completes.
//  - per_ack while per_req=0 is ignored.
//  - err_clr and a timeout in the same cycle: the set wins (bus_err=1).
// TESTING
//  - RAM write then read: write 0x0000_0010 <- 0x1234_5678, then read it back -> cpu_rdata=0x1234_5678; mio_ready 2 cycles after the write accept, 3 after the read accept.
//  - Peripheral read: read 0xE000_0000, per_ack with per_rdata=0xA5A5_0001 on the 3rd per_req cycle -> mio_ready on the next cycle, cpu_rdata=0xA5A5_0001, bus_err=0.
//  - Timeout: read 0xF000_0004 with no ack -> per_req high 16 cycles; then mio_ready, cpu_rdata=0xDEAD_BEEF, bus_err=1; err_clr pulse -> bus_err=0.
//  - Ack on the timeout cycle: per_ack coincident with the 16th per_req cycle -> per_rdata returned, bus_err=0.
//  - Reset mid-access: rst low during the 2nd PER_ACC cycle -> per_req=0 at once; no mio_ready; after release, state is IDLE.
//  - cpu_en gating: cpu_mio=1 with cpu_en=0 for 5 cycles -> no ram_en/per_req; raising cpu_en -> access accepted on that edge.

Source files
------------

// File: rtl/mio_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// mio_bus_ctrl_if
//   Bundles every bus signal around the memory/IO controller: the CPU
//   data-side request, the synchronous data RAM port, the peripheral
//   req/ack bus and the sticky error flag with its clear.
//
//   Handshakes:
//     CPU side: cpu_mio is level-held by the CPU until it sees mio_ready;
//     mio_ready is a one-cycle completion pulse and cpu_rdata is valid
//     while it is high.
//     Peripheral side: per_req is held (with per_we/per_addr/per_wdata
//     stable) until per_ack is sampled high or the controller times out;
//     per_ack is only looked at while per_req is high.
//
//   Modports:
//     slave  - the controller (mio_bus_ctrl)
//     master - the surrounding system: CPU, RAM and peripheral models
// ---------------------------------------------------------------------------
interface mio_bus_ctrl_if #(
  parameter int RAM_AW = 10
);
  // CPU request / completion
  logic              cpu_en;
  logic              cpu_mio;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              mio_ready;
  // Data RAM port
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  // Peripheral bus
  logic              per_req;
  logic              per_we;
  logic [31:0]       per_addr;
  logic [31:0]       per_wdata;
  logic [31:0]       per_rdata;
  logic              per_ack;
  // Error flag
  logic              bus_err;
  logic              err_clr;

  modport slave (
    input  cpu_en, cpu_mio, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, mio_ready,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output per_req, per_we, per_addr, per_wdata,
    input  per_rdata, per_ack,
    output bus_err,
    input  err_clr
  );

  modport master (
    output cpu_en, cpu_mio, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, mio_ready,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  per_req, per_we, per_addr, per_wdata,
    output per_rdata, per_ack,
    input  bus_err,
    output err_clr
  );
endinterface

// File: rtl/mio_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mio_bus_ctrl
//   Memory/IO bus controller behind the CPU MEM stage. Each accepted CPU
//   access is decoded on addr[31:28]: values >= PER_HI go to the peripheral
//   bus, everything else to the data RAM.
//     RAM write : accept -> RAM_ACC -> DONE             (mio_ready 2 cycles after accept)
//     RAM read  : accept -> RAM_ACC -> RAM_WAIT -> DONE (mio_ready 3 cycles after accept)
//     Peripheral: accept -> PER_ACC (until ack/timeout) -> DONE
//   A peripheral that does not ack within TIMEOUT cycles completes the
//   access with ERR_DATA and sets the sticky bus_err flag.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : mio_bus_ctrl_if.slave (CPU, RAM, peripheral, error signals)
//   state_dbg : current FSM state (IDLE=0, RAM_ACC=1, RAM_WAIT=2, PER_ACC=3, DONE=4)
//
// All bus outputs are registered.
// ---------------------------------------------------------------------------
module mio_bus_ctrl #(
  parameter int          RAM_AW   = 10,
  parameter logic [3:0]  PER_HI   = 4'hE,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mio_bus_ctrl_if.slave        bus,
  output logic [2:0]           state_dbg
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAM_ACC  = 3'd1,
    RAM_WAIT = 3'd2,
    PER_ACC  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmoCnt;
  logic             isPer;

  assign isPer     = (bus.cpu_addr[31:28] >= PER_HI);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      tmoCnt        <= '0;
      bus.mio_ready <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.per_req   <= 1'b0;
      bus.per_we    <= 1'b0;
      bus.per_addr  <= '0;
      bus.per_wdata <= '0;
      bus.bus_err   <= 1'b0;
    end else begin
      // mio_ready is a pulse: only the transition into DONE raises it.
      bus.mio_ready <= 1'b0;

      // Clear first; a timeout below re-sets the flag in the same cycle,
      // so a coincident set wins over err_clr.
      if (bus.err_clr) begin
        bus.bus_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.cpu_mio && bus.cpu_en) begin
            if (isPer) begin
              bus.per_req   <= 1'b1;
              bus.per_we    <= bus.cpu_we;
              bus.per_addr  <= bus.cpu_addr;
              bus.per_wdata <= bus.cpu_wdata;
              tmoCnt        <= '0;
              state         <= PER_ACC;
            end else begin
              bus.ram_en    <= 1'b1;
              bus.ram_we    <= bus.cpu_we;
              bus.ram_addr  <= bus.cpu_addr[RAM_AW+1:2];
              bus.ram_wdata <= bus.cpu_wdata;
              state         <= RAM_ACC;
            end
          end
        end

        RAM_ACC: begin
          // The RAM samples its port on this edge; a write is then done,
          // a read needs one more cycle for the RAM's output register.
          bus.ram_en <= 1'b0;
          bus.ram_we <= 1'b0;
          if (bus.ram_we) begin
            bus.mio_ready <= 1'b1;
            state         <= DONE;
          end else begin
            state <= RAM_WAIT;
          end
        end

        RAM_WAIT: begin
          bus.cpu_rdata <= bus.ram_rdata;
          bus.mio_ready <= 1'b1;
          state         <= DONE;
        end

        PER_ACC: begin
          // Ack is checked before the timeout so an ack on the last
          // allowed cycle still completes normally.
          if (bus.per_ack) begin
            if (!bus.per_we) begin
              bus.cpu_rdata <= bus.per_rdata;
            end
            bus.per_req   <= 1'b0;
            bus.per_we    <= 1'b0;
            bus.mio_ready <= 1'b1;
            state         <= DONE;
          end else if (tmoCnt == CNT_LAST) begin
            bus.cpu_rdata <= ERR_DATA;
            bus.bus_err   <= 1'b1;
            bus.per_req   <= 1'b0;
            bus.per_we    <= 1'b0;
            bus.mio_ready <= 1'b1;
            state         <= DONE;
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mio_bus_ctrl
//   Directed bench for mio_bus_ctrl: RAM write/read latency, peripheral
//   read/write, timeout and ack-on-timeout, err_clr priority, stray acks,
//   reset in the middle of an access and cpu_en gating.
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mio_bus_ctrl;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RAM_ACC = 3'd1;
  localparam logic [2:0] S_PER_ACC = 3'd3;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  mio_bus_ctrl_if #(.RAM_AW(10)) bus ();

  mio_bus_ctrl #(
    .RAM_AW   (10),
    .PER_HI   (4'hE),
    .TIMEOUT  (16),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Synchronous RAM model, one cycle read latency.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  int          ack_at   = 0;     // per_req cycle on which to ack (0 = never)
  logic [31:0] ack_data = '0;
  int          per_cnt;          // per_req-high cycles seen in last access
  int          ram_cnt;          // ram_en-high cycles seen in last access
  logic        seen_we;
  logic [31:0] seen_addr;
  logic [31:0] seen_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_mio   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  // Counts edges from now until mio_ready is observed; also plays the
  // peripheral by raising per_ack on per_req cycle number ack_at.
  task automatic wait_ready(output int cycles);
    per_cnt = 0;
    ram_cnt = 0;
    cycles  = 0;
    forever begin
      tick();
      cycles++;
      if (bus.ram_en) ram_cnt++;
      if (bus.per_req) begin
        per_cnt++;
        seen_we    = bus.per_we;
        seen_addr  = bus.per_addr;
        seen_wdata = bus.per_wdata;
      end
      if (bus.mio_ready) break;
      if (cycles >= 40) begin
        check("ready_bound", {31'b0, bus.mio_ready}, 32'd1);
        break;
      end
      bus.per_rdata = ack_data;
      bus.per_ack   = bus.per_req && (per_cnt == ack_at);
    end
    bus.per_ack = 1'b0;
  endtask

  // Drop the request and step past DONE back into IDLE.
  task automatic finish_access();
    bus.cpu_mio = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int   cyc;
  logic bad;

  initial begin
    bus.cpu_en    = 1'b0;
    bus.cpu_mio   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.per_rdata = '0;
    bus.per_ack   = 1'b0;
    bus.err_clr   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_mio_ready", {31'b0, bus.mio_ready}, 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_ram_en",    {31'b0, bus.ram_en}, 32'd0);
    check("rst_per_req",   {31'b0, bus.per_req}, 32'd0);
    check("rst_bus_err",   {31'b0, bus.bus_err}, 32'd0);
    check("rst_state",     {29'b0, state_dbg}, {29'b0, S_IDLE});
    rst = 1'b1;
    bus.cpu_en = 1'b1;
    tick();

    // RAM write 0x10 <- 0x12345678
    start(1'b1, 32'h0000_0010, 32'h1234_5678);
    wait_ready(cyc);
    check("ramw_latency", cyc, 32'd2);
    check("ramw_en_cycles", ram_cnt, 32'd1);
    check("ramw_rdata_kept", bus.cpu_rdata, 32'd0);
    finish_access();
    check("ramw_back_idle", {29'b0, state_dbg}, {29'b0, S_IDLE});

    // RAM read back
    start(1'b0, 32'h0000_0010, 32'h0);
    wait_ready(cyc);
    check("ramr_latency", cyc, 32'd3);
    check("ramr_rdata", bus.cpu_rdata, 32'h1234_5678);
    finish_access();

    // Peripheral read, ack on 3rd per_req cycle
    ack_at = 3; ack_data = 32'hA5A5_0001;
    start(1'b0, 32'hE000_0000, 32'h0);
    wait_ready(cyc);
    check("perr_latency", cyc, 32'd4);
    check("perr_req_cycles", per_cnt, 32'd3);
    check("perr_rdata", bus.cpu_rdata, 32'hA5A5_0001);
    check("perr_bus_err", {31'b0, bus.bus_err}, 32'd0);
    check("perr_req_low", {31'b0, bus.per_req}, 32'd0);
    finish_access();

    // Peripheral write, ack on 1st cycle; read data must be untouched
    ack_at = 1; ack_data = 32'h1111_2222;
    start(1'b1, 32'hE000_0008, 32'hCAFE_F00D);
    wait_ready(cyc);
    check("perw_latency", cyc, 32'd2);
    check("perw_we", {31'b0, seen_we}, 32'd1);
    check("perw_addr", seen_addr, 32'hE000_0008);
    check("perw_wdata", seen_wdata, 32'hCAFE_F00D);
    check("perw_rdata_kept", bus.cpu_rdata, 32'hA5A5_0001);
    finish_access();

    // Timeout: no ack
    ack_at = 0;
    start(1'b0, 32'hF000_0004, 32'h0);
    wait_ready(cyc);
    check("tmo_req_cycles", per_cnt, 32'd16);
    check("tmo_latency", cyc, 32'd17);
    check("tmo_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    check("tmo_bus_err", {31'b0, bus.bus_err}, 32'd1);
    finish_access();
    check("tmo_err_sticky", {31'b0, bus.bus_err}, 32'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("err_clr", {31'b0, bus.bus_err}, 32'd0);

    // Ack on the 16th (timeout) cycle: ack wins
    ack_at = 16; ack_data = 32'h5A5A_0016;
    start(1'b0, 32'hE000_0010, 32'h0);
    wait_ready(cyc);
    check("acktmo_latency", cyc, 32'd17);
    check("acktmo_rdata", bus.cpu_rdata, 32'h5A5A_0016);
    check("acktmo_bus_err", {31'b0, bus.bus_err}, 32'd0);
    finish_access();

    // err_clr held through a timeout: the set wins
    ack_at = 0;
    bus.err_clr = 1'b1;
    start(1'b0, 32'hF000_0000, 32'h0);
    wait_ready(cyc);
    bus.err_clr = 1'b0;
    check("setwins_bus_err", {31'b0, bus.bus_err}, 32'd1);
    finish_access();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("setwins_clr", {31'b0, bus.bus_err}, 32'd0);

    // Stray per_ack in IDLE is ignored
    bad = 1'b0;
    bus.per_ack = 1'b1;
    bus.per_rdata = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.mio_ready || state_dbg != S_IDLE || bus.cpu_rdata != 32'hDEAD_BEEF) bad = 1'b1;
    end
    bus.per_ack = 1'b0;
    check("stray_ack_ignored", {31'b0, bad}, 32'd0);

    // Reset during the 2nd PER_ACC cycle
    ack_at = 0;
    start(1'b0, 32'hE000_0100, 32'h0);
    tick();
    check("midrst_req_1st", {31'b0, bus.per_req}, 32'd1);
    check("midrst_state_1st", {29'b0, state_dbg}, {29'b0, S_PER_ACC});
    tick();
    rst = 1'b0;
    #1;
    check("midrst_req_drop", {31'b0, bus.per_req}, 32'd0);
    check("midrst_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
    bus.cpu_mio = 1'b0;
    tick();
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.mio_ready || bus.per_req || state_dbg != S_IDLE) bad = 1'b1;
    end
    check("midrst_no_ready", {31'b0, bad}, 32'd0);

    // cpu_en gating
    bus.cpu_en = 1'b0;
    start(1'b0, 32'h0000_0010, 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ram_en || bus.per_req || state_dbg != S_IDLE) bad = 1'b1;
    end
    check("en_gate_blocked", {31'b0, bad}, 32'd0);
    bus.cpu_en = 1'b1;
    tick();
    check("en_gate_accept", {29'b0, state_dbg}, {29'b0, S_RAM_ACC});
    wait_ready(cyc);
    check("en_gate_latency", cyc + 1, 32'd3);
    check("en_gate_rdata", bus.cpu_rdata, 32'h1234_5678);
    finish_access();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
